// File: rtl/ram_arb_pkg.sv
// Shared types and helpers for the RAM round-robin arbiter.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package ram_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  localparam int PERF_CNT_W = 16;
  localparam int MAX_REQ    = 8;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [PERF_CNT_W-1:0] sat_inc(input logic [PERF_CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin pick: first eligible requester strictly after ptr, wrapping.
// Latency: purely combinational.
// Backpressure: none; 'any' is low when nothing is eligible.
module rr_pick #(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] eligible,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] winner_oh,
  output logic [PTR_W-1:0]   winner_idx,
  output logic               any
);

  // Search ptr+1, ptr+2, ... ptr+NUM_REQ (the last one is ptr itself).
  always_comb begin
    int idx;
    winner_oh  = '0;
    winner_idx = '0;
    any        = 1'b0;
    idx        = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!any && eligible[idx[PTR_W-1:0]]) begin
        any                         = 1'b1;
        winner_oh[idx[PTR_W-1:0]]   = 1'b1;
        winner_idx                  = idx[PTR_W-1:0];
      end
    end
  end

endmodule

// File: rtl/single_port_sync_ram.sv
// Single-port synchronous RAM with a shared tri-state data bus.
// Latency: write commits at posedge; read data latched at negedge and driven while cs & oe & ~we.
// Backpressure: none; one access per cycle.
module single_port_sync_ram #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  cs,
  input  logic                  we,
  input  logic                  oe,
  inout  wire  [DATA_WIDTH-1:0] data
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] rd_q;

  // Write port.
  always_ff @(posedge clk) begin
    if (cs && we) mem[addr] <= data;
  end

  // Read latch in the middle of the access cycle.
  always_ff @(negedge clk) begin
    if (cs && !we) rd_q <= mem[addr];
  end

  assign data = (cs && oe && !we) ? rd_q : {DATA_WIDTH{1'bz}};

endmodule

// File: rtl/ram_rr_arbiter.sv
// Round-robin sequencer sharing one single-port sync RAM among NUM_REQ requesters (optional RAM_ARB_PERF_EN counters).
// Latency: req seen in IDLE cycle T -> gnt/RAM cycle T+1 -> rsp_valid T+2; one access per 2 cycles.
// Backpressure: requesters hold req/payload until their rsp_valid pulse; losers simply wait.
module ram_rr_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_REQ-1:0]               req,
  input  logic [NUM_REQ-1:0]               req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
  output logic [NUM_REQ-1:0]               gnt,
  output logic [NUM_REQ-1:0]               rsp_valid,
  output logic [DATA_WIDTH-1:0]            rsp_rdata,
  output logic [ADDR_WIDTH-1:0]            ram_addr,
  output logic                             ram_cs,
  output logic                             ram_we,
  output logic                             ram_oe,
`ifdef RAM_ARB_PERF_EN
  output logic [NUM_REQ*PERF_CNT_W-1:0]    perf_grant_cnt,
  output logic [PERF_CNT_W-1:0]            perf_conflict_cnt,
`endif
  inout  wire  [DATA_WIDTH-1:0]            ram_data
);

  localparam int PTR_W = $clog2(NUM_REQ);

  state_t                 state_q, state_d;
  logic [PTR_W-1:0]       ptr_q;
  logic [DATA_WIDTH-1:0]  wdata_q;
  logic [NUM_REQ-1:0]     eligible;
  logic [NUM_REQ-1:0]     win_oh;
  logic [PTR_W-1:0]       win_idx;
  logic                   win_any;
  logic                   start, finish;
  logic [ADDR_WIDTH-1:0]  sel_addr;
  logic [DATA_WIDTH-1:0]  sel_wdata;
  logic                   sel_we;

  // The requester being answered this cycle cannot be re-granted yet.
  assign eligible = req & ~rsp_valid;

  rr_pick #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_pick (
    .eligible   (eligible),
    .ptr        (ptr_q),
    .winner_oh  (win_oh),
    .winner_idx (win_idx),
    .any        (win_any)
  );

  // Select the winner's payload from the flattened request buses.
  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_we    = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_oh[i]) begin
        sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
        sel_we    = req_we[i];
      end
    end
  end

  // Next-state logic: IDLE waits for an eligible request, ACCESS lasts one cycle.
  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    finish  = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_any) begin
          state_d = ACCESS;
          start   = 1'b1;
        end
      end
      ACCESS: begin
        state_d = IDLE;
        finish  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Registered grant, RAM control and response path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q     <= PTR_W'(NUM_REQ - 1);
      gnt       <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
      ram_addr  <= '0;
      ram_cs    <= 1'b0;
      ram_we    <= 1'b0;
      ram_oe    <= 1'b0;
      wdata_q   <= '0;
    end else begin
      rsp_valid <= '0;
      if (start) begin
        ptr_q    <= win_idx;
        gnt      <= win_oh;
        ram_addr <= sel_addr;
        ram_we   <= sel_we;
        ram_oe   <= ~sel_we;
        ram_cs   <= 1'b1;
        wdata_q  <= sel_wdata;
      end else if (finish) begin
        rsp_valid <= gnt;
        gnt       <= '0;
        ram_cs    <= 1'b0;
        ram_we    <= 1'b0;
        ram_oe    <= 1'b0;
        // RAM drove its read data since the mid-cycle negedge.
        if (!ram_we) rsp_rdata <= ram_data;
      end
    end
  end

  // Drive the shared bus only during a write access.
  assign ram_data = (ram_cs & ram_we) ? wdata_q : {DATA_WIDTH{1'bz}};

`ifdef RAM_ARB_PERF_EN
  logic [PERF_CNT_W-1:0] grant_cnt [NUM_REQ];
  logic [PERF_CNT_W-1:0] conflict_cnt;

  // Saturating grant and contention counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REQ; i++) grant_cnt[i] <= '0;
      conflict_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (start && win_oh[i]) grant_cnt[i] <= sat_inc(grant_cnt[i]);
      end
      if (state_q == IDLE && $countones(eligible) >= 2)
        conflict_cnt <= sat_inc(conflict_cnt);
    end
  end

  // Flatten the per-requester counters onto the output bus.
  always_comb begin
    perf_grant_cnt = '0;
    for (int i = 0; i < NUM_REQ; i++)
      perf_grant_cnt[i*PERF_CNT_W +: PERF_CNT_W] = grant_cnt[i];
  end

  assign perf_conflict_cnt = conflict_cnt;
`endif

endmodule

// File: tb/tb_ram_rr_arbiter.sv
// Scoreboard bench for ram_rr_arbiter with a single_port_sync_ram behind it.
// Expected grants and responses are queued at stimulus time and popped by a monitor.
// Inputs are driven 1 time unit after posedge; outputs are sampled at negedge.
module tb_ram_rr_arbiter;

  localparam int AW = 6;
  localparam int DW = 8;
  localparam int NR = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NR-1:0]     req = '0;
  logic [NR-1:0]     req_we = '0;
  logic [NR*AW-1:0]  req_addr = '0;
  logic [NR*DW-1:0]  req_wdata = '0;
  logic [NR-1:0]     gnt;
  logic [NR-1:0]     rsp_valid;
  logic [DW-1:0]     rsp_rdata;
  logic [AW-1:0]     ram_addr;
  logic              ram_cs, ram_we, ram_oe;
  wire  [DW-1:0]     ram_data;
`ifdef RAM_ARB_PERF_EN
  logic [NR*16-1:0]  perf_grant_cnt;
  logic [15:0]       perf_conflict_cnt;
`endif

  ram_rr_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REQ(NR)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .gnt       (gnt),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .ram_addr  (ram_addr),
    .ram_cs    (ram_cs),
    .ram_we    (ram_we),
    .ram_oe    (ram_oe),
`ifdef RAM_ARB_PERF_EN
    .perf_grant_cnt    (perf_grant_cnt),
    .perf_conflict_cnt (perf_conflict_cnt),
`endif
    .ram_data  (ram_data)
  );

  single_port_sync_ram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) u_ram (
    .clk  (clk),
    .addr (ram_addr),
    .cs   (ram_cs),
    .we   (ram_we),
    .oe   (ram_oe),
    .data (ram_data)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          rd;
    logic [DW-1:0] dat;
  } rsp_exp_t;

  rsp_exp_t      exp_rsp_q [NR][$];
  int            exp_gnt_q [$];
  logic [DW-1:0] model_mem [2**AW];
  int            cyc = 0;
  int            n_checks = 0;
  int            n_fail = 0;
  logic [NR-1:0] gnt_prev = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Queue the expected grant and response for one access, updating the memory model.
  task automatic expect_access(input int i, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    rsp_exp_t e;
    if (we) begin
      e.rd = 1'b0;
      e.dat = d;
      model_mem[a] = d;
    end else begin
      e.rd = 1'b1;
      e.dat = model_mem[a];
    end
    exp_rsp_q[i].push_back(e);
    exp_gnt_q.push_back(i);
  endtask

  // One request/response handshake for requester i.
  task automatic do_access(input int i, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input bit chk_lat);
    int t0;
    int n;
    @(posedge clk); #1;
    req_we[i] = we;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
    req[i] = 1'b1;
    t0 = cyc;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!gnt[i] && n < 20);
    if (!gnt[i]) check("gnt_timeout", 32'(gnt[i]), 1);
    else if (chk_lat) check("lat_gnt", 32'(cyc - t0), 1);
    n = 0;
    while (!rsp_valid[i] && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!rsp_valid[i]) check("rsp_timeout", 32'(rsp_valid[i]), 1);
    else if (chk_lat) check("lat_rsp", 32'(cyc - t0), 2);
    @(posedge clk); #1;
    req[i] = 1'b0;
  endtask

  // Hold a read request high for n responses, checking the spacing between them.
  task automatic hold_reads(input int i, input logic [AW-1:0] a, input int n);
    int got;
    int gap;
    int guard;
    got = 0;
    gap = -1;
    guard = 0;
    @(posedge clk); #1;
    req_we[i] = 1'b0;
    req_addr[i*AW +: AW] = a;
    req[i] = 1'b1;
    while (got < n && guard < 100) begin
      @(negedge clk);
      guard++;
      gap++;
      if (rsp_valid[i]) begin
        got++;
        check("rr_gap_le4", 32'(gap <= 4), 1);
        gap = 0;
      end
    end
    if (got < n) check("rr_timeout", 32'(got), 32'(n));
    @(posedge clk); #1;
    req[i] = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: bus protocol every cycle, grant order and response data from the scoreboard.
  always @(negedge clk) begin
    int       e;
    rsp_exp_t r;
    if (!rst_n) begin
      gnt_prev <= '0;
    end else begin
      check("bus_we_and_oe", 32'(ram_we & ram_oe), 0);
      check("cs_vs_gnt", 32'(ram_cs), 32'(|gnt));
      check("oe_vs_we", 32'(ram_oe), 32'(ram_cs & ~ram_we));
      check("gnt_onehot", 32'($onehot0(gnt)), 1);
      check("rsp_onehot", 32'($onehot0(rsp_valid)), 1);
      if (gnt != '0 && gnt_prev == '0) begin
        if (exp_gnt_q.size() == 0) begin
          check("gnt_unexpected", 32'(gnt), 0);
        end else begin
          e = exp_gnt_q.pop_front();
          check("gnt_order", 32'(gnt), 32'(1 << e));
        end
      end
      for (int i = 0; i < NR; i++) begin
        if (rsp_valid[i]) begin
          if (exp_rsp_q[i].size() == 0) begin
            check("rsp_unexpected", 32'(i), 32'hFFFF);
          end else begin
            r = exp_rsp_q[i].pop_front();
            if (r.rd) check("rsp_rdata", 32'(rsp_rdata), 32'(r.dat));
          end
        end
      end
      gnt_prev <= gnt;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // Reset values.
    repeat (3) @(negedge clk);
    check("rst_gnt", 32'(gnt), 0);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_rsp_rdata", 32'(rsp_rdata), 0);
    check("rst_ram_addr", 32'(ram_addr), 0);
    check("rst_ram_cs", 32'(ram_cs), 0);
    check("rst_ram_we", 32'(ram_we), 0);
    check("rst_ram_oe", 32'(ram_oe), 0);
    rst_n = 1'b1;

    // Write then read back through requester 0, with latency checks.
    expect_access(0, 1'b1, 6'd5, 8'hA5);
    do_access(0, 1'b1, 6'd5, 8'hA5, 1'b1);
    expect_access(0, 1'b0, 6'd5, 8'h00);
    do_access(0, 1'b0, 6'd5, 8'h00, 1'b1);

    // Seed two locations, one per requester.
    expect_access(0, 1'b1, 6'd10, 8'h5A);
    do_access(0, 1'b1, 6'd10, 8'h5A, 1'b1);
    expect_access(1, 1'b1, 6'd20, 8'hC3);
    do_access(1, 1'b1, 6'd20, 8'hC3, 1'b1);

    // Both requesters read continuously: grants must alternate starting with 0.
    for (int k = 0; k < 4; k++) begin
      expect_access(0, 1'b0, 6'd10, 8'h00);
      expect_access(1, 1'b0, 6'd20, 8'h00);
    end
    fork
      hold_reads(0, 6'd10, 4);
      hold_reads(1, 6'd20, 4);
    join

    // Read/write race on 0x3F after reset: req0 reads old data, then req1 writes.
    expect_access(0, 1'b1, 6'h3F, 8'h11);
    do_access(0, 1'b1, 6'h3F, 8'h11, 1'b1);
    apply_reset();
    expect_access(0, 1'b0, 6'h3F, 8'h00);
    expect_access(1, 1'b1, 6'h3F, 8'h3C);
    fork
      do_access(0, 1'b0, 6'h3F, 8'h00, 1'b0);
      do_access(1, 1'b1, 6'h3F, 8'h3C, 1'b0);
    join
    expect_access(0, 1'b0, 6'h3F, 8'h00);
    do_access(0, 1'b0, 6'h3F, 8'h00, 1'b1);

    // Reset asserted in the middle of an ACCESS cycle.
    exp_gnt_q.push_back(0);
    @(posedge clk); #1;
    req_we[0] = 1'b0;
    req_addr[0 +: AW] = 6'd10;
    req[0] = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!gnt[0] && n < 20);
    check("midrst_granted", 32'(gnt[0]), 1);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_cs_async", 32'(ram_cs), 0);
    check("midrst_gnt_async", 32'(gnt), 0);
    check("midrst_oe_async", 32'(ram_oe), 0);
    req[0] = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("midrst_no_rsp", 32'(rsp_valid), 0);
    end
    check("midrst_rdata_cleared", 32'(rsp_rdata), 0);
    rst_n = 1'b1;
    expect_access(0, 1'b0, 6'd10, 8'h00);
    expect_access(1, 1'b0, 6'd20, 8'h00);
    fork
      do_access(0, 1'b0, 6'd10, 8'h00, 1'b0);
      do_access(1, 1'b0, 6'd20, 8'h00, 1'b0);
    join

`ifdef RAM_ARB_PERF_EN
    // Counters: 10 grants to req0, 3 grants to req1, 3 contended IDLE cycles.
    apply_reset();
    for (int k = 0; k < 7; k++) begin
      expect_access(0, 1'b1, 6'(32 + k), 8'(k));
      do_access(0, 1'b1, 6'(32 + k), 8'(k), 1'b0);
    end
    for (int k = 0; k < 3; k++) begin
      expect_access(0, 1'b1, 6'd40, 8'(k));
      expect_access(1, 1'b1, 6'd41, 8'(k));
      fork
        do_access(0, 1'b1, 6'd40, 8'(k), 1'b0);
        do_access(1, 1'b1, 6'd41, 8'(k), 1'b0);
      join
    end
    @(negedge clk);
    check("perf_grant0", 32'(perf_grant_cnt[15:0]), 10);
    check("perf_grant1", 32'(perf_grant_cnt[31:16]), 3);
    check("perf_conflict", 32'(perf_conflict_cnt), 3);
`endif

    repeat (3) @(negedge clk);
    check("left_gnt_q", 32'(exp_gnt_q.size()), 0);
    check("left_rsp0_q", 32'(exp_rsp_q[0].size()), 0);
    check("left_rsp1_q", 32'(exp_rsp_q[1].size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
